// File: rtl/audio_pkg.sv
// Shared I2S frame geometry for the tone player audio output path.
// Slot counts are fixed by the 32-bit-per-channel I2S framing used with the codec.
package audio_pkg;

  localparam int I2S_SLOTS_PER_FRAME   = 64;
  localparam int I2S_SLOTS_PER_CHANNEL = 32;
  localparam int I2S_DATA_DELAY        = 1;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_channel_e;

  function automatic int slot_clocks(input int bclk_div_log2);
    return 1 << (bclk_div_log2 + 1);
  endfunction

  function automatic int frame_clocks(input int bclk_div_log2);
    return I2S_SLOTS_PER_FRAME * slot_clocks(bclk_div_log2);
  endfunction

endpackage

// File: rtl/amplitude_ramp.sv
// Saturating per-frame amplitude slew toward a target, used for click-free volume changes.
// amp_o shows the post-step value so the caller can latch it on the step edge itself.
module amplitude_ramp #(
  parameter int AMP_BITS  = 15,
  parameter int RAMP_STEP = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                step_i,
  input  logic [AMP_BITS-1:0] target_i,
  output logic [AMP_BITS-1:0] amp_o
);

  localparam logic [AMP_BITS:0] STEP_W = (AMP_BITS+1)'(RAMP_STEP);

  logic [AMP_BITS-1:0] amp_q, amp_d;
  logic [AMP_BITS:0]   up_w, dn_w, tgt_w;

  always_comb begin
    amp_d = amp_q;
    tgt_w = {1'b0, target_i};
    up_w  = {1'b0, amp_q} + STEP_W;
    dn_w  = {1'b0, amp_q} - STEP_W;
    if (step_i) begin
      // One bit of headroom: the top bit of dn_w flags an underflow past zero.
      if (amp_q < target_i) begin
        amp_d = (up_w > tgt_w) ? target_i : up_w[AMP_BITS-1:0];
      end else if (amp_q > target_i) begin
        amp_d = (dn_w[AMP_BITS] || (dn_w < tgt_w)) ? target_i : dn_w[AMP_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      amp_q <= '0;
    end else begin
      amp_q <= amp_d;
    end
  end

  assign amp_o = amp_d;

endmodule

// File: rtl/tone_i2s_output.sv
// Square-wave tone to signed PCM with volume ramping, serialised as I2S (codec in slave mode).
// Same sample goes to both channels; all outputs are registered and reflect the current phase.
module tone_i2s_output
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS   = 16,
  parameter int VOLUME_BITS   = 4,
  parameter int BCLK_DIV_LOG2 = 3,
  parameter int RAMP_STEP     = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   sound,
  input  logic [VOLUME_BITS-1:0] volume,
  output logic                   aud_bclk,
  output logic                   aud_daclrck,
  output logic                   aud_dacdat,
  output logic                   sample_strobe,
  output logic [SAMPLE_BITS-1:0] sample_value
);

  localparam int AMP_BITS      = SAMPLE_BITS - 1;
  localparam int SLOT_LOG2     = BCLK_DIV_LOG2 + 1;
  localparam int SLOT_BITS     = $clog2(I2S_SLOTS_PER_FRAME);
  localparam int CH_SLOT_BITS  = $clog2(I2S_SLOTS_PER_CHANNEL);
  localparam int PHASE_BITS    = SLOT_BITS + SLOT_LOG2;
  localparam int VOL_SHIFT     = AMP_BITS - VOLUME_BITS;
  localparam logic [PHASE_BITS-1:0] LAST_PHASE =
    PHASE_BITS'(frame_clocks(BCLK_DIV_LOG2) - 1);

  logic [PHASE_BITS-1:0]   phase_q, phase_d;
  logic                    bclk_q, bclk_d;
  logic                    lrck_q, lrck_d;
  logic                    dat_q, dat_d;
  logic                    strobe_q, strobe_d;
  logic [SAMPLE_BITS-1:0]  sample_q, sample_d;
  logic [SAMPLE_BITS-1:0]  shreg_q, shreg_d;

  logic                    wrap;
  logic                    slot_start;
  logic [SLOT_BITS-1:0]    slot_d;
  logic [CH_SLOT_BITS-1:0] chan_slot;
  logic [AMP_BITS-1:0]     target;
  logic [AMP_BITS-1:0]     amp_new;
  logic [SAMPLE_BITS-1:0]  magnitude;

  assign wrap   = (phase_q == LAST_PHASE);
  assign target = enable ? (AMP_BITS'(volume) << VOL_SHIFT) : '0;

  amplitude_ramp #(
    .AMP_BITS  (AMP_BITS),
    .RAMP_STEP (RAMP_STEP)
  ) u_ramp (
    .clock    (clock),
    .reset    (reset),
    .step_i   (wrap),
    .target_i (target),
    .amp_o    (amp_new)
  );

  assign magnitude = {1'b0, amp_new};

  always_comb begin
    phase_d    = phase_q + 1'b1;
    slot_d     = phase_d[PHASE_BITS-1 -: SLOT_BITS];
    chan_slot  = slot_d[CH_SLOT_BITS-1:0];
    slot_start = (phase_d[SLOT_LOG2-1:0] == '0);

    bclk_d   = phase_d[SLOT_LOG2-1];
    lrck_d   = slot_d[SLOT_BITS-1] ? CH_RIGHT : CH_LEFT;
    strobe_d = wrap;
    sample_d = wrap ? (sound ? magnitude : -magnitude) : sample_q;

    dat_d   = dat_q;
    shreg_d = shreg_q;
    // Data moves only on BCLK falling edges; once the word has shifted out the
    // register is empty, so the unused tail slots naturally send zeros.
    if (slot_start) begin
      if (chan_slot == '0) begin
        dat_d   = 1'b0;
        shreg_d = sample_d;
      end else if (chan_slot < CH_SLOT_BITS'(I2S_DATA_DELAY)) begin
        dat_d = 1'b0;
      end else begin
        dat_d   = shreg_q[SAMPLE_BITS-1];
        shreg_d = {shreg_q[SAMPLE_BITS-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q  <= '0;
      bclk_q   <= 1'b0;
      lrck_q   <= 1'b0;
      dat_q    <= 1'b0;
      strobe_q <= 1'b0;
      sample_q <= '0;
      shreg_q  <= '0;
    end else begin
      phase_q  <= phase_d;
      bclk_q   <= bclk_d;
      lrck_q   <= lrck_d;
      dat_q    <= dat_d;
      strobe_q <= strobe_d;
      sample_q <= sample_d;
      shreg_q  <= shreg_d;
    end
  end

  assign aud_bclk      = bclk_q;
  assign aud_daclrck   = lrck_q;
  assign aud_dacdat    = dat_q;
  assign sample_strobe = strobe_q;
  assign sample_value  = sample_q;

endmodule

// File: tb/tb_tone_i2s_output.sv
// Directed bench for tone_i2s_output with a short frame (4-clock slots) and a 700-LSB ramp step
// so full ramps fit in a short run; 700 does not divide the targets, exercising the clamp.
module tb_tone_i2s_output;

  localparam int SB    = 16;
  localparam int VB    = 4;
  localparam int DIVL  = 1;
  localparam int STEP  = 700;
  localparam int SLOT  = 1 << (DIVL + 1);
  localparam int FRAME = 64 * SLOT;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          sound = 1'b0;
  logic [VB-1:0] volume = '0;
  logic          aud_bclk, aud_daclrck, aud_dacdat, sample_strobe;
  logic [SB-1:0] sample_value;

  int total = 0;
  int bad = 0;
  int proto_errs = 0;
  int bclk_falls = 0;

  always #5 clock = ~clock;

  tone_i2s_output #(
    .SAMPLE_BITS   (SB),
    .VOLUME_BITS   (VB),
    .BCLK_DIV_LOG2 (DIVL),
    .RAMP_STEP     (STEP)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .sound         (sound),
    .volume        (volume),
    .aud_bclk      (aud_bclk),
    .aud_daclrck   (aud_daclrck),
    .aud_dacdat    (aud_dacdat),
    .sample_strobe (sample_strobe),
    .sample_value  (sample_value)
  );

  // Data and word select may only move together with a BCLK falling edge.
  logic mon_bclk = 1'b0, mon_lrck = 1'b0, mon_dat = 1'b0, rst_edge;
  always @(posedge clock) begin
    rst_edge = reset;
    #1;
    if (!rst_edge) begin
      if (mon_bclk && !aud_bclk) bclk_falls++;
      if ((aud_dacdat !== mon_dat) && !(mon_bclk && !aud_bclk)) proto_errs++;
      if ((aud_daclrck !== mon_lrck) && !(mon_bclk && !aud_bclk)) proto_errs++;
    end
    mon_bclk = aud_bclk;
    mon_lrck = aud_daclrck;
    mon_dat  = aud_dacdat;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sample_strobe && n < 2 * FRAME);
  endtask

  // Starts on an observed phase-0 cycle, ends on the next one.
  task automatic run_frame(input bit flip_sound, output logic [SB-1:0] left, output logic [SB-1:0] right);
    int terr, zerr, slot, sub, s;
    terr = 0;
    zerr = 0;
    left = '0;
    right = '0;
    for (int p = 0; p < FRAME; p++) begin
      slot = p / SLOT;
      sub  = p % SLOT;
      if (aud_bclk !== (sub >= SLOT / 2)) terr++;
      if (aud_daclrck !== (slot >= 32)) terr++;
      if (sample_strobe !== (p == 0)) terr++;
      if (sub == SLOT - 1) begin
        s = slot % 32;
        if (s >= 1 && s <= SB) begin
          if (slot < 32) left[SB - s] = aud_dacdat;
          else           right[SB - s] = aud_dacdat;
        end else if (aud_dacdat !== 1'b0) begin
          zerr++;
        end
      end
      if (flip_sound && p == FRAME / 2) sound = 1'b0;
      tick();
    end
    chk("frame_timing", terr, 0);
    chk("zero_slots", zerr, 0);
  endtask

  task automatic run_frames(input int n);
    logic [SB-1:0] l, r;
    for (int i = 0; i < n; i++) run_frame(1'b0, l, r);
  endtask

  initial begin
    int n;
    logic [SB-1:0] l, r;

    repeat (3) tick();
    chk("rst_bclk", aud_bclk, 0);
    chk("rst_lrck", aud_daclrck, 0);
    chk("rst_dat", aud_dacdat, 0);
    chk("rst_strobe", sample_strobe, 0);
    chk("rst_sample", sample_value, 0);

    reset = 1'b0;
    wait_strobe(n);
    chk("first_strobe", n, FRAME);

    // Disabled: silence, framing still runs
    run_frame(1'b0, l, r);
    chk("idle_left", l, 0);
    chk("idle_right", r, 0);
    run_frame(1'b0, l, r);
    chk("idle_sample", sample_value, 0);

    // Ramp up to full volume
    enable = 1'b1;
    volume = 4'd15;
    sound  = 1'b1;
    run_frames(1);
    chk("ramp_up_1", sample_value, 16'd700);
    run_frames(42);
    chk("ramp_up_43", sample_value, 16'd30100);
    run_frames(1);
    chk("ramp_up_sat", sample_value, 16'h7800);
    run_frame(1'b0, l, r);
    chk("full_left", l, 16'h7800);
    chk("full_right", r, 16'h7800);
    chk("full_hold", sample_value, 16'h7800);

    // Sound flips mid-frame: current frame unaffected, next is negative
    run_frame(1'b1, l, r);
    chk("flip_cur_left", l, 16'h7800);
    chk("flip_cur_right", r, 16'h7800);
    chk("flip_sample", sample_value, 16'h8800);
    sound = 1'b1;
    run_frame(1'b0, l, r);
    chk("neg_left", l, 16'h8800);
    chk("neg_right", r, 16'h8800);
    chk("pos_again", sample_value, 16'h7800);

    // Ramp down to volume 8, then to silence
    volume = 4'd8;
    run_frames(1);
    chk("ramp_dn_1", sample_value, 16'd30020);
    run_frames(19);
    chk("ramp_dn_20", sample_value, 16'd16720);
    run_frames(1);
    chk("ramp_dn_sat", sample_value, 16'h4000);
    run_frames(1);
    chk("ramp_dn_hold", sample_value, 16'h4000);
    enable = 1'b0;
    run_frames(23);
    chk("fade_23", sample_value, 16'd284);
    run_frames(1);
    chk("fade_zero", sample_value, 0);
    sound = 1'b0;
    run_frames(1);
    chk("neg_zero", sample_value, 0);
    sound = 1'b1;

    // Mid-frame reset at full amplitude
    enable = 1'b1;
    volume = 4'd15;
    run_frames(44);
    chk("reramp_sat", sample_value, 16'h7800);
    repeat (150) tick();
    chk("pre_rst_bclk", aud_bclk, 1);
    chk("pre_rst_lrck", aud_daclrck, 1);
    chk("pre_rst_dat", aud_dacdat, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_bclk", aud_bclk, 0);
    chk("mid_rst_lrck", aud_daclrck, 0);
    chk("mid_rst_dat", aud_dacdat, 0);
    chk("mid_rst_strobe", sample_strobe, 0);
    chk("mid_rst_sample", sample_value, 0);
    reset = 1'b0;
    wait_strobe(n);
    chk("post_rst_strobe", n, FRAME);
    chk("post_rst_amp", sample_value, 16'd700);

    chk("proto_errs", proto_errs, 0);
    chk("proto_seen", (bclk_falls > 1000), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
